// File: rtl/fma_pkg.sv
// Shared constants, FSM encoding and flag bundle for the FMA normalize/round back end.
package fma_pkg;

  localparam int unsigned MAG_W       = 74;
  localparam int unsigned EXP_W       = 10;
  localparam int unsigned XW          = EXP_W + 1;
  localparam int unsigned SIG_W       = 24;
  localparam int unsigned EXP_BIAS    = 127;
  localparam int          EMIN        = -126;
  localparam int unsigned EMAX_BIASED = 255;
  localparam int unsigned HIDDEN_POS  = 72;
  localparam int unsigned GUARD_POS   = 48;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
    logic zero;
  } flags_t;

endpackage

// File: rtl/fma_norm_round_if.sv
// Handshake and payload bundle between the FMA front end, this back end and its consumer.
interface fma_norm_round_if;

  logic                          in_valid;
  logic                          in_ready;
  logic [fma_pkg::MAG_W-1:0]     sum_mag;
  logic                          sum_sign;
  logic [fma_pkg::EXP_W-1:0]     exp_tmp;
  logic                          out_valid;
  logic                          out_ready;
  logic [31:0]                   result;
  logic                          flag_ovf;
  logic                          flag_unf;
  logic                          flag_inx;
  logic                          flag_zero;

  modport master (
    output in_valid, sum_mag, sum_sign, exp_tmp, out_ready,
    input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_inx, flag_zero
  );

  modport slave (
    input  in_valid, sum_mag, sum_sign, exp_tmp, out_ready,
    output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inx, flag_zero
  );

endinterface

// File: rtl/fma_norm_round_lzc8.sv
// 8-bit leading-zero counter; returns 8 for an all-zero input.
module lzc8 (
  input  logic [7:0] din,
  output logic [3:0] cnt
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    cnt = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (din[i]) cnt = 4'(7 - i);
    end
  end

endmodule

// File: rtl/fma_norm_round.sv
// FMA back end: iterative normalize, round-to-nearest-even, IEEE-754 single pack.
// Define FMA_DENORM_EN for gradual underflow; default build flushes tiny results to zero.
module fma_norm_round
  import fma_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  fma_norm_round_if.slave     bus
);

  localparam logic signed [XW-1:0] EMIN_X     = XW'(EMIN);
  localparam logic signed [XW-1:0] EMAX_X     = XW'(EMAX_BIASED);
  localparam logic        [XW-1:0] EXP_BIAS_X = XW'(EXP_BIAS);

  state_e                 state_q, state_d;
  logic [MAG_W-1:0]       mag_q, mag_d;
  logic signed [XW-1:0]   exp_q, exp_d;
  logic                   sign_q, sign_d;
  logic                   sticky_q, sticky_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [31:0]            result_q, result_d;
  flags_t                 flags_q, flags_d;

  logic [3:0]             lz;
  logic [3:0]             sh;
  logic [SIG_W:0]         sig_rnd;
  logic                   guard, sticky_all, rnd_up, hidden_r, zero_sum;
  logic signed [XW-1:0]   exp_r, eb;
  logic [7:0]             exp_field;
  logic [31:0]            pack_res;
  flags_t                 pack_flg;
`ifdef FMA_DENORM_EN
  logic signed [XW-1:0]   headroom;
`endif

  lzc8 u_lzc8 (
    .din (mag_q[HIDDEN_POS -: 8]),
    .cnt (lz)
  );

  // Rounding fields; a significand carry-out leaves frac at zero and bumps the exponent.
  always_comb begin
    guard      = mag_q[GUARD_POS];
    sticky_all = sticky_q | (|mag_q[GUARD_POS-1:0]);
    rnd_up     = guard & (sticky_all | mag_q[GUARD_POS+1]);
    sig_rnd    = {1'b0, mag_q[HIDDEN_POS -: SIG_W]} + {{SIG_W{1'b0}}, rnd_up};
    hidden_r   = sig_rnd[SIG_W] | sig_rnd[SIG_W-1];
    exp_r      = exp_q + {{(XW-1){1'b0}}, sig_rnd[SIG_W]};
    eb         = exp_r + EXP_BIAS_X;
    exp_field  = hidden_r ? eb[7:0] : 8'd0;
    zero_sum   = (mag_q == '0) && !sticky_q;
  end

  always_comb begin
    pack_res = '0;
    pack_flg = '0;
    if (zero_sum) begin
      pack_flg.zero = 1'b1;
    end else if (eb >= EMAX_X) begin
      pack_res     = {sign_q, 8'hFF, 23'd0};
      pack_flg.ovf = 1'b1;
      pack_flg.inx = 1'b1;
`ifndef FMA_DENORM_EN
    end else if (exp_r < EMIN_X) begin
      pack_res      = {sign_q, 31'd0};
      pack_flg.unf  = 1'b1;
      pack_flg.inx  = 1'b1;
      pack_flg.zero = 1'b1;
`endif
    end else begin
      pack_res      = {sign_q, exp_field, sig_rnd[SIG_W-2:0]};
      pack_flg.inx  = guard | sticky_all;
      pack_flg.zero = ~|{exp_field, sig_rnd[SIG_W-2:0]};
`ifdef FMA_DENORM_EN
      pack_flg.unf  = !mag_q[HIDDEN_POS] & (guard | sticky_all);
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    sh          = lz;
`ifdef FMA_DENORM_EN
    headroom    = exp_q - EMIN_X;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          mag_d    = bus.sum_mag;
          sign_d   = bus.sum_sign;
          exp_d    = {bus.exp_tmp[EXP_W-1], bus.exp_tmp};
          sticky_d = 1'b0;
          state_d  = ST_NORM;
        end
      end
      ST_NORM: begin
        if (mag_q[MAG_W-1]) begin
          mag_d    = mag_q >> 1;
          sticky_d = sticky_q | mag_q[0];
          exp_d    = exp_q + XW'(1);
        end else if (mag_q == '0) begin
          state_d = ST_ROUND;
`ifdef FMA_DENORM_EN
        end else if (exp_q < EMIN_X) begin
          mag_d    = mag_q >> 1;
          sticky_d = sticky_q | mag_q[0];
          exp_d    = exp_q + XW'(1);
`endif
        end else if (mag_q[HIDDEN_POS]) begin
          state_d = ST_ROUND;
        end else begin
`ifdef FMA_DENORM_EN
          // Clamp at EMIN: the remaining significand is subnormal.
          if (headroom == '0)               state_d = ST_ROUND;
          else if (headroom < XW'(lz))      sh      = 4'(headroom);
`endif
          if (state_d == ST_NORM) begin
            mag_d = mag_q << sh;
            exp_d = exp_q - XW'(sh);
          end
        end
      end
      ST_ROUND: begin
        result_d    = pack_res;
        flags_d     = pack_flg;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mag_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      sticky_q    <= sticky_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_ovf  = flags_q.ovf;
  assign bus.flag_unf  = flags_q.unf;
  assign bus.flag_inx  = flags_q.inx;
  assign bus.flag_zero = flags_q.zero;

endmodule

// File: tb/tb_fma_norm_round.sv
// Scoreboard bench for fma_norm_round: directed vectors, decoupled output monitor.
module tb_fma_norm_round;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fma_norm_round_if bus ();

  fma_norm_round dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: compare each new result against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output: got %h with no pending operation", bus.result);
      end else begin
        mon_e = sb.pop_front();
        chk("result", bus.result, mon_e.res);
        chk("flags", 32'({bus.flag_ovf, bus.flag_unf, bus.flag_inx, bus.flag_zero}), 32'(mon_e.flg));
        chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
    ov_prev = bus.out_valid;
  end

  function automatic logic [73:0] bit_at(input int p);
    logic [73:0] m;
    m    = '0;
    m[p] = 1'b1;
    return m;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_chk++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
    end
  endtask

  task automatic issue(input logic [73:0] mag, input logic sgn, input int e,
                       input logic [31:0] res, input logic [3:0] flg, input int lat);
    exp_t x;
    wait_ready();
    bus.sum_mag  = mag;
    bus.sum_sign = sgn;
    bus.exp_tmp  = 10'(e);
    bus.in_valid = 1'b1;
    x.res = res; x.flg = flg; x.lat = lat; x.acc = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int w = 0;
    while (!bus.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      n_chk++;
      $display("FAIL out_valid_timeout: got 0 expected 1 within 50 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [73:0] m;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sum_mag   = '0;
    bus.sum_sign  = 1'b0;
    bus.exp_tmp   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_flags", 32'({bus.flag_ovf, bus.flag_unf, bus.flag_inx, bus.flag_zero}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // flags packed as {ovf, unf, inx, zero}
    issue(bit_at(72), 1'b0, 0, 32'h3F80_0000, 4'b0000, 2);
    issue(bit_at(73), 1'b0, 0, 32'h4000_0000, 4'b0000, 3);
    issue(74'd1, 1'b0, 72, 32'h3F80_0000, 4'b0000, 11);
    issue(bit_at(72) | bit_at(48), 1'b0, 0, 32'h3F80_0000, 4'b0010, 2);
    issue(bit_at(72) | bit_at(49) | bit_at(48), 1'b0, 0, 32'h3F80_0002, 4'b0010, 2);
    issue(74'd0, 1'b0, 0, 32'h0000_0000, 4'b0001, 2);
    issue(bit_at(72), 1'b1, 128, 32'hFF80_0000, 4'b1010, 2);
`ifdef FMA_DENORM_EN
    issue(bit_at(72), 1'b0, -127, 32'h0040_0000, 4'b0000, 3);
`else
    issue(bit_at(72), 1'b0, -127, 32'h0000_0000, 4'b0111, 2);
`endif
    issue(bit_at(70) | bit_at(69), 1'b0, 3, 32'h4040_0000, 4'b0000, 3);
    m = ((74'(1) << 25) - 74'(1)) << 48;
    issue(m, 1'b0, 0, 32'h4000_0000, 4'b0010, 2);

    // Backpressure: result must hold while out_ready is low.
    wait_ready();
    bus.out_ready = 1'b0;
    issue(bit_at(72) | bit_at(71), 1'b1, 0, 32'hBFC0_0000, 4'b0000, 2);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result", bus.result, 32'hBFC0_0000);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a long normalization discards the operation.
    wait_ready();
    bus.sum_mag  = 74'd1;
    bus.sum_sign = 1'b0;
    bus.exp_tmp  = 10'd72;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result", bus.result, 32'h0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", 32'(bus.in_ready), 32'd1);
    issue(bit_at(72), 1'b0, 0, 32'h3F80_0000, 4'b0000, 2);

    begin
      int w = 0;
      while ((sb.size() != 0 || bus.out_valid) && w < 100) begin
        @(negedge clk);
        w++;
      end
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fma_norm_round.md
Name: fma_norm_round

Overview:
- Back end of the single-precision FMA datapath. Consumes the aligned 74-bit sum magnitude and the 10-bit signed working exponent produced by the exponent/alignment front end.
- Normalizes iteratively (left shift by up to 8 per cycle, or right shift by 1 on carry), then rounds to nearest-even and packs an IEEE-754 single result.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- MAG_W, 74, sum magnitude width; bit 73 = carry, bit 72 = hidden-bit position.
- EXP_W, 10, working exponent width, two's complement, unbiased.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept; high only in IDLE.
- sum_mag  in  74  unsigned sum magnitude; value = sum_mag × 2^(exp_tmp−72).
- sum_sign  in  1  sign of the sum.
- exp_tmp  in  10  signed unbiased exponent weighting bit 72.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}.
- flag_ovf  out  1  overflow.
- flag_unf  out  1  underflow.
- flag_inx  out  1  inexact.
- flag_zero  out  1  result is zero.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. While rst is high: state IDLE, out_valid=0, result=0, all flags=0, in_ready=0. Reset mid-operation discards the in-flight operation, with no output.
- FSM has four states: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. When in_valid=1, latch mag, sign, exp, clear sticky, go to NORM.
- NORM: one action per cycle, in priority order:
  - mag[73]=1: mag>>1, sticky |= shifted-out bit, exp+1, stay.
  - mag[72]=1: go to ROUND, no shift.
  - mag==0: go to ROUND (zero path).
  - mag[72:65]==0: mag<<8, exp−8.
  - else: shift left by the leading-zero count of mag[72:65] (1..7), exp minus that count.
- NORM cycle bound: at most 10 cycles.
- ROUND:
  - Fields: significand = mag[72:49], guard = mag[48], sticky_all = sticky | OR(mag[47:0]).
  - Round up iff guard & (sticky_all | mag[49]).
  - Significand carry-out sets the significand to 1.0 and increments exp.
  - Biased exponent eb = exp+127, computed at 11 bits signed.
  - eb≥255: result = ±inf (0x7F800000 | sign<<31), ovf=1, inx=1.
  - eb≤0 (when DENORM_EN is off): result = ±0, unf=1, inx=1, zero=1.
  - Zero sum: result = 0x00000000 (+0), zero=1, no other flags.
  - Otherwise: normal pack, inx = guard | sticky_all.
  - Register outputs, then go to DONE.
- DONE: out_valid=1. result and flags are held stable while out_ready=0. When out_ready=1, drop out_valid and go to IDLE the next cycle. No new input is accepted in DONE.
- Latency: out_valid rises 2 + k cycles after the accept edge, where k = number of shift cycles in NORM.
- Throughput: at most one result per 3 + k cycles.

Optional Feature:
- Macro: FMA_DENORM_EN.
- Defined: gradual underflow.
  - NORM left shifts are clamped so exp never falls below −126. When the clamp is reached, go to ROUND with the subnormal significand.
  - Inputs with exp < −126 are right-shifted in NORM, with sticky accumulated, until exp = −126.
  - Pack with eb=0. unf=1 only if the result is tiny and inexact. Rounding up to 0x00800000 yields a normal result.
- Undefined: flush-to-zero, as described in Behaviour.

Decomposition:
- Shared package fma_pkg:
  - Constants: MAG_W, EXP_W, EXP_BIAS=127, EMIN=−126, EMAX_BIASED=255, HIDDEN_POS=72, GUARD_POS=48.
  - FSM state encoding.
  - Flag bundle typedef.
- Sub-module lzc8: 8-bit leading-zero counter (output 0..8) used by NORM.

Test Plan:
- sum_mag=1<<72, exp_tmp=0, sign=0 → result 0x3F800000, no flags, out_valid exactly 2 cycles after the accept edge.
- sum_mag=1<<73, exp_tmp=0 → 0x40000000, out_valid at 3 cycles. Then sum_mag=1, exp_tmp=72 → 0x3F800000, out_valid at 11 cycles (9 shift-by-8 steps).
- RNE tie: (1<<72)|(1<<48) → 0x3F800000, inx=1. (1<<72)|(1<<49)|(1<<48) → 0x3F800002, inx=1. sum_mag=0 → 0x00000000, zero=1.
- exp_tmp=128, sum_mag=1<<72, sign=1 → 0xFF800000, ovf=1, inx=1. exp_tmp=−127 without FMA_DENORM_EN → 0x00000000, unf=1. With FMA_DENORM_EN → 0x00400000.
- Backpressure: hold out_ready=0 for 5 cycles → result stable, in_ready=0. Release → out_valid drops and in_ready=1 the next cycle.
- Assert rst in NORM mid-shift → next cycle IDLE, out_valid=0, result=0. A following 1.0 operation completes correctly.
